// File: rtl/smul_accum.sv
// smul_accum: block accumulator for sign-magnitude product words.
// Each term is converted to two's complement and added into a
// saturating running sum. After L terms the block result is held on
// sum/ovf until the consumer takes it.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for the first term of a block; latches the length
// S_ACC  | accumulating the remaining terms of the block
// S_DONE | result presented on sum/ovf; new terms are held off
module smul_accum #(
   parameter int DATAWIDTH = 8,
   parameter int ACCWIDTH  = 16,
   parameter int LENWIDTH  = 4
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [DATAWIDTH-1:0] prod,
   input  logic                 prod_valid,
   output logic                 prod_ready,
   input  logic [LENWIDTH-1:0]  len,
   output logic [ACCWIDTH-1:0]  sum,
   output logic                 sum_valid,
   input  logic                 sum_ready,
   output logic                 ovf
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [ACCWIDTH-1:0] ACC_MAX = {1'b0, {(ACCWIDTH-1){1'b1}}};
   localparam logic [ACCWIDTH-1:0] ACC_MIN = {1'b1, {(ACCWIDTH-1){1'b0}}};

   state_t              state, state_nxt;
   logic [ACCWIDTH-1:0] acc, acc_nxt;
   logic [LENWIDTH-1:0] cnt, cnt_nxt;
   logic [LENWIDTH-1:0] len_l, len_l_nxt;
   logic                ovf_r, ovf_nxt;

   logic                term_xfer;
   logic                sum_xfer;
   logic [ACCWIDTH-1:0] mag_ext;
   logic [ACCWIDTH-1:0] term;
   logic [ACCWIDTH:0]   add_full;
   logic                add_sat;
   logic [ACCWIDTH-1:0] add_res;
   logic [LENWIDTH-1:0] len_eff;
   logic [LENWIDTH-1:0] cnt_inc;

   assign term_xfer = prod_valid && prod_ready;
   assign sum_xfer  = sum_valid && sum_ready;

   // Sign-magnitude to two's complement; a negative zero negates to zero.
   always_comb begin
      mag_ext = {{(ACCWIDTH-DATAWIDTH+1){1'b0}}, prod[DATAWIDTH-2:0]};
      term    = prod[DATAWIDTH-1] ? (~mag_ext + 1'b1) : mag_ext;
   end

   // Saturating add: one guard bit exposes overflow in either direction.
   always_comb begin
      add_full = {acc[ACCWIDTH-1], acc} + {term[ACCWIDTH-1], term};
      add_sat  = add_full[ACCWIDTH] != add_full[ACCWIDTH-1];
      if (add_sat) begin
         add_res = add_full[ACCWIDTH] ? ACC_MIN : ACC_MAX;
      end else begin
         add_res = add_full[ACCWIDTH-1:0];
      end
   end

   // A zero length is treated as a single-term block.
   always_comb begin
      len_eff = (len == '0) ? LENWIDTH'(1) : len;
      cnt_inc = cnt + LENWIDTH'(1);
   end

   // State register.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (term_xfer) begin
               state_nxt = (len_eff == LENWIDTH'(1)) ? S_DONE : S_ACC;
            end
         end
         S_ACC: begin
            if (term_xfer && (cnt_inc == len_l)) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (sum_xfer) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from state; ready is held off only while a result waits.
   always_comb begin
      prod_ready = (state != S_DONE);
      sum_valid  = (state == S_DONE);
      sum        = acc;
      ovf        = ovf_r;
   end

   // Datapath next values: first term loads, later terms accumulate.
   always_comb begin
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      len_l_nxt = len_l;
      ovf_nxt   = ovf_r;
      if (term_xfer) begin
         if (state == S_IDLE) begin
            acc_nxt   = term;
            cnt_nxt   = LENWIDTH'(1);
            len_l_nxt = len_eff;
            ovf_nxt   = 1'b0;
         end else if (state == S_ACC) begin
            acc_nxt = add_res;
            cnt_nxt = cnt_inc;
            ovf_nxt = ovf_r | add_sat;
         end
      end
   end

   // Datapath registers; reset discards any partial block.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         acc   <= '0;
         cnt   <= '0;
         len_l <= '0;
         ovf_r <= 1'b0;
      end else begin
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
         len_l <= len_l_nxt;
         ovf_r <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_smul_accum.sv
// Directed bench for smul_accum: default instance (ACCWIDTH=16) plus a
// narrow instance (ACCWIDTH=10) for the saturation scenario.
module tb_smul_accum;

   logic       clk;
   logic       rst;

   logic [7:0]  prod;
   logic        prod_valid;
   logic        prod_ready;
   logic [3:0]  len;
   logic [15:0] sum;
   logic        sum_valid;
   logic        sum_ready;
   logic        ovf;

   logic [7:0]  prod10;
   logic        prod_valid10;
   logic        prod_ready10;
   logic [3:0]  len10;
   logic [9:0]  sum10;
   logic        sum_valid10;
   logic        sum_ready10;
   logic        ovf10;

   int n_tests;
   int n_fail;

   smul_accum u_dut (
      .Clk        (clk),
      .Rst        (rst),
      .prod       (prod),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .len        (len),
      .sum        (sum),
      .sum_valid  (sum_valid),
      .sum_ready  (sum_ready),
      .ovf        (ovf)
   );

   smul_accum #(.DATAWIDTH(8), .ACCWIDTH(10), .LENWIDTH(4)) u_dut10 (
      .Clk        (clk),
      .Rst        (rst),
      .prod       (prod10),
      .prod_valid (prod_valid10),
      .prod_ready (prod_ready10),
      .len        (len10),
      .sum        (sum10),
      .sum_valid  (sum_valid10),
      .sum_ready  (sum_ready10),
      .ovf        (ovf10)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called at a negedge; returns just after the posedge that transferred the term.
   task automatic drive_term(input logic [7:0] p, input logic [3:0] l, output bit ok);
      int b;
      b = 0;
      prod = p;
      len = l;
      prod_valid = 1'b1;
      while (!prod_ready && b < 50) begin
         @(negedge clk);
         b++;
      end
      ok = prod_ready;
      if (ok) @(posedge clk);
   endtask

   task automatic drive_term10(input logic [7:0] p, input logic [3:0] l, output bit ok);
      int b;
      b = 0;
      prod10 = p;
      len10 = l;
      prod_valid10 = 1'b1;
      while (!prod_ready10 && b < 50) begin
         @(negedge clk);
         b++;
      end
      ok = prod_ready10;
      if (ok) @(posedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      n_tests++;
      if (prod_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_prod_ready: got %b want 1", prod_ready);
      end
      n_tests++;
      if (sum_valid !== 1'b0 || sum !== 16'h0000 || ovf !== 1'b0) begin
         n_fail++; $display("FAIL reset_outputs: got valid=%b sum=%h ovf=%b want 0/0000/0", sum_valid, sum, ovf);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (prod_ready !== 1'b1 || sum_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_release: got ready=%b valid=%b want 1/0", prod_ready, sum_valid);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      sum_ready = 1'b1;
      drive_term(8'h05, 4'd3, ok);
      @(negedge clk);
      drive_term(8'h83, 4'd1, ok);
      @(negedge clk);
      n_tests++;
      if (sum_valid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_early_valid: got %b want 0", sum_valid);
      end
      drive_term(8'h02, 4'd7, ok);
      n_tests++;
      if (ok !== 1'b1) begin
         n_fail++; $display("FAIL b2b_accept: got %b want 1", ok);
      end
      @(negedge clk);
      prod_valid = 1'b0;
      n_tests++;
      if (sum_valid !== 1'b1 || sum !== 16'h0004 || ovf !== 1'b0) begin
         n_fail++; $display("FAIL b2b_result: got valid=%b sum=%h ovf=%b want 1/0004/0", sum_valid, sum, ovf);
      end
      n_tests++;
      if (prod_ready !== 1'b0) begin
         n_fail++; $display("FAIL b2b_done_ready: got %b want 0", prod_ready);
      end
      @(negedge clk);
      n_tests++;
      if (sum_valid !== 1'b0 || prod_ready !== 1'b1) begin
         n_fail++; $display("FAIL b2b_one_cycle: got valid=%b ready=%b want 0/1", sum_valid, prod_ready);
      end
   endtask

   task automatic test_len_zero();
      bit ok;
      sum_ready = 1'b1;
      drive_term(8'h80, 4'd0, ok);
      @(negedge clk);
      prod_valid = 1'b0;
      n_tests++;
      if (sum_valid !== 1'b1 || sum !== 16'h0000 || ovf !== 1'b0) begin
         n_fail++; $display("FAIL len_zero: got valid=%b sum=%h ovf=%b want 1/0000/0", sum_valid, sum, ovf);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      bit ok;
      bit bad;
      sum_ready = 1'b0;
      drive_term(8'h7F, 4'd2, ok);
      @(negedge clk);
      drive_term(8'h81, 4'd2, ok);
      @(negedge clk);
      prod = 8'h01;
      len = 4'd1;
      prod_valid = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (prod_ready !== 1'b0 || sum_valid !== 1'b1 || sum !== 16'h007E || ovf !== 1'b0) bad = 1'b1;
         @(negedge clk);
      end
      n_tests++;
      if (bad !== 1'b0) begin
         n_fail++; $display("FAIL bp_hold: got unstable or ready during stall, now sum=%h ready=%b want 007E/0", sum, prod_ready);
      end
      sum_ready = 1'b1;
      n_tests++;
      if (prod_ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_no_bypass: got ready=%b want 0", prod_ready);
      end
      @(negedge clk);
      n_tests++;
      if (prod_ready !== 1'b1 || sum_valid !== 1'b0) begin
         n_fail++; $display("FAIL bp_release: got ready=%b valid=%b want 1/0", prod_ready, sum_valid);
      end
      @(negedge clk);
      prod_valid = 1'b0;
      n_tests++;
      if (sum_valid !== 1'b1 || sum !== 16'h0001) begin
         n_fail++; $display("FAIL bp_held_term: got valid=%b sum=%h want 1/0001", sum_valid, sum);
      end
      @(negedge clk);
   endtask

   task automatic test_saturation();
      bit ok;
      sum_ready10 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive_term10(8'h7F, 4'd5, ok);
         @(negedge clk);
      end
      prod_valid10 = 1'b0;
      n_tests++;
      if (sum_valid10 !== 1'b1 || sum10 !== 10'd511 || ovf10 !== 1'b1) begin
         n_fail++; $display("FAIL sat_pos: got valid=%b sum=%0d ovf=%b want 1/511/1", sum_valid10, sum10, ovf10);
      end
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         drive_term10(8'hFF, 4'd5, ok);
         @(negedge clk);
      end
      prod_valid10 = 1'b0;
      n_tests++;
      if (sum_valid10 !== 1'b1 || sum10 !== 10'h200 || ovf10 !== 1'b1) begin
         n_fail++; $display("FAIL sat_neg: got valid=%b sum=%h ovf=%b want 1/200/1", sum_valid10, sum10, ovf10);
      end
      @(negedge clk);
      drive_term10(8'h01, 4'd1, ok);
      @(negedge clk);
      prod_valid10 = 1'b0;
      n_tests++;
      if (sum_valid10 !== 1'b1 || sum10 !== 10'd1 || ovf10 !== 1'b0) begin
         n_fail++; $display("FAIL sat_clear: got valid=%b sum=%0d ovf=%b want 1/1/0", sum_valid10, sum10, ovf10);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_block();
      bit ok;
      bit seen;
      sum_ready = 1'b1;
      drive_term(8'h01, 4'd4, ok);
      @(negedge clk);
      drive_term(8'h02, 4'd4, ok);
      @(negedge clk);
      prod_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_tests++;
      if (prod_ready !== 1'b1 || sum_valid !== 1'b0 || sum !== 16'h0000) begin
         n_fail++; $display("FAIL mid_reset_clear: got ready=%b valid=%b sum=%h want 1/0/0000", prod_ready, sum_valid, sum);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (sum_valid !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_no_result: got sum_valid seen=%b want 0", seen);
      end
      drive_term(8'h09, 4'd1, ok);
      @(negedge clk);
      prod_valid = 1'b0;
      n_tests++;
      if (sum_valid !== 1'b1 || sum !== 16'h0009) begin
         n_fail++; $display("FAIL mid_reset_new_block: got valid=%b sum=%h want 1/0009", sum_valid, sum);
      end
      @(negedge clk);
   endtask

   task automatic test_random_valid();
      logic [7:0] t;
      int m;
      int v;
      bit m_ovf;
      bit done;
      bit vld;
      bit rdy;
      int b;
      int spurious;
      bit timeout;
      sum_ready = 1'b1;
      for (int blk = 0; blk < 2; blk++) begin
         m = 0;
         m_ovf = 1'b0;
         spurious = 0;
         timeout = 1'b0;
         for (int i = 0; i < 15; i++) begin
            t = 8'($urandom_range(0, 255));
            v = t[7] ? -int'(t[6:0]) : int'(t[6:0]);
            if (i == 0) begin
               m = v;
            end else begin
               m = m + v;
               if (m > 32767) begin m = 32767; m_ovf = 1'b1; end
               if (m < -32768) begin m = -32768; m_ovf = 1'b1; end
            end
            done = 1'b0;
            b = 0;
            while (!done && b < 200) begin
               @(negedge clk);
               if (sum_valid) spurious++;
               vld = 1'($urandom_range(0, 1));
               prod_valid = vld;
               prod = vld ? t : 8'($urandom_range(0, 255));
               len = (i == 0) ? 4'd15 : 4'($urandom_range(0, 15));
               rdy = prod_ready;
               @(posedge clk);
               if (vld && rdy) done = 1'b1;
               b++;
            end
            if (!done) timeout = 1'b1;
         end
         @(negedge clk);
         prod_valid = 1'b0;
         n_tests++;
         if (timeout !== 1'b0 || spurious !== 0) begin
            n_fail++; $display("FAIL rand_flow blk%0d: got timeout=%b early_valid=%0d want 0/0", blk, timeout, spurious);
         end
         n_tests++;
         if (sum_valid !== 1'b1 || sum !== 16'(m) || ovf !== m_ovf) begin
            n_fail++; $display("FAIL rand_sum blk%0d: got valid=%b sum=%h ovf=%b want 1/%h/%b", blk, sum_valid, sum, ovf, 16'(m), m_ovf);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail = 0;
      rst = 1'b1;
      prod = 8'h00;
      prod_valid = 1'b0;
      len = 4'd0;
      sum_ready = 1'b0;
      prod10 = 8'h00;
      prod_valid10 = 1'b0;
      len10 = 4'd0;
      sum_ready10 = 1'b0;
      test_reset();
      test_back_to_back();
      test_len_zero();
      test_backpressure();
      test_saturation();
      test_reset_mid_block();
      test_random_valid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/smul_accum.md
SMUL_ACCUM -- requirements
Module: smul_accum

Interface
REQ-001 Parameter DATAWIDTH, default 8, SHALL be the width of one sign-magnitude product word.
REQ-002 Parameter ACCWIDTH, default 16, SHALL be the width of the two's-complement running sum; ACCWIDTH > DATAWIDTH.
REQ-003 Parameter LENWIDTH, default 4, SHALL be the width of the block-length input.
REQ-004 Port Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port Rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 Port prod  input  DATAWIDTH  SHALL carry a product word in sign-magnitude format: MSB = sign, low DATAWIDTH-1 bits = magnitude.
REQ-007 Port prod_valid  input  1  SHALL indicate prod is valid.
REQ-008 Port prod_ready  output  1  SHALL indicate the block accepts prod this cycle.
REQ-009 Port len  input  LENWIDTH  SHALL give the number of terms per block; it is sampled only with the first term.
REQ-010 Port sum  output  ACCWIDTH  SHALL carry the signed block result.
REQ-011 Port sum_valid  output  1  SHALL indicate sum is valid.
REQ-012 Port sum_ready  input  1  SHALL indicate the consumer takes sum this cycle.
REQ-013 Port ovf  output  1  SHALL flag that saturation occurred in the presented block.

Function
REQ-014 Transfer rules: a term transfers when prod_valid && prod_ready; a result transfers when sum_valid && sum_ready.
REQ-015 Term conversion: each term SHALL be converted to ACCWIDTH two's complement as +mag or -mag; 0x80-style negative zero SHALL equal 0.
REQ-016 FSM states SHALL be IDLE, ACC and DONE; prod_ready = 1 in IDLE and ACC, 0 in DONE; sum_valid = 1 only in DONE.
REQ-017 IDLE transfer: latch L = (len==0 ? 1 : len); set acc = term, cnt = 1, ovf = 0; go to DONE if L==1, else to ACC.
REQ-018 ACC transfer: set acc = sat(acc + term) and cnt = cnt + 1; go to DONE when the new cnt equals L; no transfer leaves state and registers unchanged.
REQ-019 Saturation: each addition SHALL saturate to +(2^(ACCWIDTH-1)-1) or -(2^(ACCWIDTH-1)); any saturation sets ovf, which stays set until the next block starts.
REQ-020 Result timing: sum and ovf SHALL be registered, reflect acc, be valid the cycle after the last term transfer, and stay stable while sum_valid && !sum_ready.
REQ-021 DONE exit: on result transfer, go to IDLE; prod_ready rises the following cycle, with no same-cycle bypass.
REQ-022 Backpressure: in DONE, prod_valid SHALL be ignored and no term is lost; the upstream holds it.
REQ-023 Independence: len changes after the first term SHALL NOT affect the current block.

Reset
REQ-024 Rst assertion SHALL immediately force state IDLE and clear acc, cnt, L, sum, ovf and sum_valid.
REQ-025 While Rst is high, prod_ready SHALL be 1.
REQ-026 A reset mid-block SHALL discard the partial sum; no result is produced.
REQ-027 Rst SHALL be sampled asynchronously on assertion and released synchronously to Clk.

Verification
REQ-028 Scenario 1: len=3, terms 0x05, 0x83, 0x02 back-to-back, sum_ready=1 -> sum=0x0004, ovf=0, sum_valid high exactly 1 cycle after the 3rd transfer.
REQ-029 Scenario 2: len=0, term 0x80 -> block treated as length 1; sum=0x0000, ovf=0.
REQ-030 Scenario 3: len=2, terms 0x7F, 0x81; sum_ready low 3 cycles with prod_valid held high -> prod_ready=0 throughout; sum=0x007E stable; next term accepted the cycle after sum_ready rises.
REQ-031 Scenario 4: ACCWIDTH=10, len=5, five 0x7F terms -> sum=511, ovf=1; then five 0xFF terms -> sum=-512, ovf=1; then len=1, term 0x01 -> sum=1, ovf=0.
REQ-032 Scenario 5: len=4, after 2 terms assert Rst for 1 cycle -> no sum_valid; new block len=1, term 0x09 -> sum=0x0009.
REQ-033 Scenario 6: prod_valid toggled randomly over len=15 blocks -> each sum equals the reference model; no term dropped or duplicated.
